// File: rtl/nn_pkg.sv
// Shared types and default constants for the MNIST run sequencer.
package nn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_W  = 3'd1,
    ST_LOAD_X  = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_DONE    = 3'd4
  } nn_state_e;

  localparam int unsigned W_COUNT_DEF    = 78400;
  localparam int unsigned X_COUNT_DEF    = 784;
  localparam int unsigned TIMEOUT_DEF    = 1 << 20;
  localparam int unsigned W_LOAD_SEL_DEF = 0;
  localparam int unsigned X_LOAD_SEL_DEF = 0;
  localparam int unsigned SEL_IDLE       = 0;

  // Bits needed to hold 0..n-1 (at least one bit).
  function automatic int cnt_bits(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nn_load_counter.sv
// Beat counter for one memory load: counts accepted beats and flags the
// terminal beat so the sequencer can leave the load state on it.
module nn_load_counter
  import nn_pkg::*;
#(
  parameter int          WIDTH = 8,
  parameter int unsigned COUNT = 256
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             incr_i,
  output logic [WIDTH-1:0] count_o,
  output logic             last_o
);

  localparam logic [WIDTH-1:0] LAST_VAL = WIDTH'(COUNT - 1);

  logic [WIDTH-1:0] count_q, count_d;

  // Next count: clear has priority over increment.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (incr_i) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign last_o  = (count_q == LAST_VAL);

endmodule

// File: rtl/nn_run_ctrl.sv
// Run sequencer: streams weights and pixels into mem_sys, then hands the
// memory port to compute_module and waits for finish or timeout.
//
//   state      | meaning
//   IDLE       | waiting for start
//   LOAD_W     | accepting weight bits, one write per beat
//   LOAD_X     | accepting pixel bits, one write per beat
//   COMPUTE    | compute_module owns memory, en_compute high after 1st cycle
//   DONE       | one-cycle done pulse, then back to IDLE
module nn_run_ctrl
  import nn_pkg::*;
#(
  parameter int          W_ADDR_LEN = 20,
  parameter int          X_ADDR_LEN = 10,
  parameter int          W_SEL_LEN  = 2,
  parameter int          X_SEL_LEN  = 2,
  parameter int unsigned W_COUNT    = W_COUNT_DEF,
  parameter int unsigned X_COUNT    = X_COUNT_DEF,
  parameter int unsigned W_LOAD_SEL = W_LOAD_SEL_DEF,
  parameter int unsigned X_LOAD_SEL = X_LOAD_SEL_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  skip_w,
  input  logic                  s_valid,
  input  logic                  s_data,
  output logic                  s_ready,
  output logic                  load_compute_ctrl,
  output logic                  w_wq_oc,
  output logic                  x_wq_oc,
  output logic [W_ADDR_LEN-1:0] w_addr_oc,
  output logic [X_ADDR_LEN-1:0] x_addr_oc,
  output logic                  wx_write_oc,
  output logic [W_SEL_LEN-1:0]  w_sel_oc,
  output logic [X_SEL_LEN-1:0]  x_sel_oc,
  output logic                  en_compute,
  input  logic                  compute_finish,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err
);

  localparam int             T_W    = cnt_bits(TIMEOUT);
  localparam logic [T_W-1:0] T_LAST = T_W'(TIMEOUT - 1);

  nn_state_e state_q, state_d;

  logic                  s_ready_q, lcc_q, en_q, busy_q, done_q;
  logic                  terr_q, terr_d;
  logic                  w_wq_q, x_wq_q, wdata_q;
  logic [W_ADDR_LEN-1:0] w_addr_q;
  logic [X_ADDR_LEN-1:0] x_addr_q;
  logic [W_SEL_LEN-1:0]  w_sel_q;
  logic [X_SEL_LEN-1:0]  x_sel_q;
  logic [T_W-1:0]        tcnt_q, tcnt_d;

  logic                  beat, w_clr, x_clr, w_inc, x_inc, w_last, x_last;
  logic [W_ADDR_LEN-1:0] w_cnt;
  logic [X_ADDR_LEN-1:0] x_cnt;
  logic                  compute_hold;

  assign beat = s_valid & s_ready_q;

  nn_load_counter #(.WIDTH(W_ADDR_LEN), .COUNT(W_COUNT)) u_w_cnt (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clear_i (w_clr),
    .incr_i  (w_inc),
    .count_o (w_cnt),
    .last_o  (w_last)
  );

  nn_load_counter #(.WIDTH(X_ADDR_LEN), .COUNT(X_COUNT)) u_x_cnt (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clear_i (x_clr),
    .incr_i  (x_inc),
    .count_o (x_cnt),
    .last_o  (x_last)
  );

  // Next state, counter controls and sticky error.
  // tcnt_q == 0 marks the first COMPUTE cycle, where finish may be stale.
  always_comb begin
    state_d = state_q;
    w_clr   = 1'b0;
    x_clr   = 1'b0;
    w_inc   = 1'b0;
    x_inc   = 1'b0;
    terr_d  = terr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          w_clr   = 1'b1;
          x_clr   = 1'b1;
          terr_d  = 1'b0;
          state_d = skip_w ? ST_LOAD_X : ST_LOAD_W;
        end
      end
      ST_LOAD_W: begin
        if (beat) begin
          w_inc = 1'b1;
          if (w_last) state_d = ST_LOAD_X;
        end
      end
      ST_LOAD_X: begin
        if (beat) begin
          x_inc = 1'b1;
          if (x_last) state_d = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        if (compute_finish && (tcnt_q != '0)) begin
          state_d = ST_DONE;
        end else if (tcnt_q == T_LAST) begin
          state_d = ST_DONE;
          terr_d  = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Timeout counter runs only while computing and restarts on entry.
  assign tcnt_d = (state_q == ST_COMPUTE) ? tcnt_q + T_W'(1) : '0;

  // Compute owns the port from the second COMPUTE cycle, so the final pixel
  // write (presented in the first COMPUTE cycle) still reaches memory.
  assign compute_hold = (state_q == ST_COMPUTE) && (state_d == ST_COMPUTE);

  // State, timeout counter and control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tcnt_q    <= '0;
      terr_q    <= 1'b0;
      s_ready_q <= 1'b0;
      lcc_q     <= 1'b1;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      terr_q    <= terr_d;
      s_ready_q <= (state_d == ST_LOAD_W) || (state_d == ST_LOAD_X);
      lcc_q     <= !compute_hold;
      en_q      <= compute_hold;
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_DONE);
    end
  end

  // Memory write port: one-cycle write per accepted beat; addresses hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_wq_q   <= 1'b0;
      x_wq_q   <= 1'b0;
      wdata_q  <= 1'b0;
      w_addr_q <= '0;
      x_addr_q <= '0;
      w_sel_q  <= '0;
      x_sel_q  <= '0;
    end else begin
      w_wq_q  <= 1'b0;
      x_wq_q  <= 1'b0;
      wdata_q <= 1'b0;
      w_sel_q <= W_SEL_LEN'(SEL_IDLE);
      x_sel_q <= X_SEL_LEN'(SEL_IDLE);
      if (beat && (state_q == ST_LOAD_W)) begin
        w_wq_q   <= 1'b1;
        w_addr_q <= w_cnt;
        wdata_q  <= s_data;
        w_sel_q  <= W_SEL_LEN'(W_LOAD_SEL);
      end else if (beat && (state_q == ST_LOAD_X)) begin
        x_wq_q   <= 1'b1;
        x_addr_q <= x_cnt;
        wdata_q  <= s_data;
        x_sel_q  <= X_SEL_LEN'(X_LOAD_SEL);
      end
    end
  end

  assign s_ready           = s_ready_q;
  assign load_compute_ctrl = lcc_q;
  assign en_compute        = en_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign timeout_err       = terr_q;
  assign w_wq_oc           = w_wq_q;
  assign x_wq_oc           = x_wq_q;
  assign w_addr_oc         = w_addr_q;
  assign x_addr_oc         = x_addr_q;
  assign wx_write_oc       = wdata_q;
  assign w_sel_oc          = w_sel_q;
  assign x_sel_oc          = x_sel_q;

endmodule
